// File: rtl/cont_bright_pipe.sv
// Two-stage contrast/brightness engine: out = clamp(round(alpha*pix) + beta) on LANES packed pixels.
// Optional saturation counter output sat_count is built when CONT_BRIGHT_SAT_CNT_EN is defined.
module cont_bright_pipe #(
  parameter int PIX_W      = 8,
  parameter int LANES      = 4,
  parameter int ALPHA_W    = 8,
  parameter int ALPHA_FRAC = 4,
  parameter int BETA_W     = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_load,
  input  logic [ALPHA_W-1:0]       cfg_alpha,
  input  logic [BETA_W-1:0]        cfg_beta,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*PIX_W-1:0]   in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*PIX_W-1:0]   out_data,
  output logic                     sat_flag
`ifdef CONT_BRIGHT_SAT_CNT_EN
  ,
  output logic [15:0]              sat_count
`endif
);

  localparam int DW = LANES * PIX_W;
  localparam int PW = ALPHA_W + PIX_W;
  localparam int SW = PW + BETA_W + 2;
  localparam logic [ALPHA_W-1:0] ALPHA_ONE = {{(ALPHA_W-1){1'b0}}, 1'b1} << ALPHA_FRAC;
  // Half an LSB of the fractional part; collapses to zero for integer gain.
  localparam logic [PW:0] RND = ({{PW{1'b0}}, 1'b1} << ALPHA_FRAC) >> 1;
  localparam logic signed [SW-1:0] MAXV = {{(SW-PIX_W){1'b0}}, {PIX_W{1'b1}}};

  logic [ALPHA_W-1:0]          alpha_q;
  logic [BETA_W-1:0]           beta_q;
  logic                        s1_valid;
  logic [LANES-1:0][PW-1:0]    s1_prod;
  logic [BETA_W-1:0]           s1_beta;
  logic                        out_valid_q;
  logic [DW-1:0]               out_data_q;
  logic [LANES-1:0]            sat_lanes_q;
  logic [LANES-1:0][PW-1:0]    prod_in;
  logic [DW-1:0]               next_data;
  logic [LANES-1:0]            lane_sat;
  logic                        en;

  // Valid/ready: a beat moves across an interface on a clock edge where valid
  // and ready are both high; the whole pipe advances only when the output
  // register is empty or being drained, so in_ready never depends on in_valid.
  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alpha_q <= ALPHA_ONE;
      beta_q  <= '0;
    end else if (cfg_load) begin
      alpha_q <= cfg_alpha;
      beta_q  <= cfg_beta;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    localparam int LO = (LANES - 1 - l) * PIX_W;
    logic [PW:0]                rnd_sum;
    logic [PW-ALPHA_FRAC:0]     r;
    logic signed [SW-1:0]       s;
    logic [PIX_W-1:0]           lane_pix;
    logic                       lane_clamp;

    assign prod_in[l] = {{PIX_W{1'b0}}, alpha_q} * {{ALPHA_W{1'b0}}, in_data[LO +: PIX_W]};
    assign rnd_sum    = {1'b0, s1_prod[l]} + RND;
    assign r          = rnd_sum[PW:ALPHA_FRAC];
    assign s          = $signed({{(SW-PW+ALPHA_FRAC-1){1'b0}}, r})
                      + $signed({{(SW-BETA_W){s1_beta[BETA_W-1]}}, s1_beta});

    always_comb begin
      lane_pix   = s[PIX_W-1:0];
      lane_clamp = 1'b0;
      if (s < 0) begin
        lane_pix   = '0;
        lane_clamp = 1'b1;
      end else if (s > MAXV) begin
        lane_pix   = '1;
        lane_clamp = 1'b1;
      end
    end

    assign next_data[LO +: PIX_W] = lane_pix;
    assign lane_sat[l]            = lane_clamp;
  end

  // Each beat carries its own beta copy; alpha is already folded into the product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_prod     <= '0;
      s1_beta     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sat_lanes_q <= '0;
    end else if (en) begin
      s1_valid    <= in_valid;
      out_valid_q <= s1_valid;
      if (in_valid) begin
        s1_prod <= prod_in;
        s1_beta <= beta_q;
      end
      if (s1_valid) begin
        out_data_q  <= next_data;
        sat_lanes_q <= lane_sat;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sat_flag  = |sat_lanes_q;

`ifdef CONT_BRIGHT_SAT_CNT_EN
  logic [16:0] cnt_sum;

  always_comb begin
    cnt_sum = {1'b0, sat_count} + 17'($countones(sat_lanes_q));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_count <= '0;
    end else if (cfg_load) begin
      sat_count <= '0;
    end else if (out_valid_q && out_ready) begin
      sat_count <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_cont_bright_pipe.sv
// Bench for cont_bright_pipe: directed literal cases plus randomized traffic against a
// per-beat arithmetic model; covers sat_count too when CONT_BRIGHT_SAT_CNT_EN is defined.
module tb_cont_bright_pipe;
  localparam int DW = 32;
  localparam int W  = DW + 8;
  localparam int FRAC_DIV = 16;
  localparam int HALF     = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_load;
  logic [7:0]    cfg_alpha;
  logic [8:0]    cfg_beta;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          sat_flag;
`ifdef CONT_BRIGHT_SAT_CNT_EN
  logic [15:0]   sat_count;
`endif

  cont_bright_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_load  (cfg_load),
    .cfg_alpha (cfg_alpha),
    .cfg_beta  (cfg_beta),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sat_flag  (sat_flag)
`ifdef CONT_BRIGHT_SAT_CNT_EN
    ,
    .sat_count (sat_count)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0]  exp_q[$];
  logic [7:0]    alpha_m = 8'h10;
  logic [8:0]    beta_m  = 9'h000;
  int            cnt_m   = 0;
  int            n_checks = 0;
  int            n_fail   = 0;
  int            out_cnt  = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_sat;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic, lane 0 in the top byte.
  function automatic void model_beat(input logic [7:0] a, input logic [8:0] b,
                                     input logic [DW-1:0] d,
                                     output logic [DW-1:0] o, output int nsat);
    int p, s, ai, bi;
    o    = '0;
    nsat = 0;
    ai   = int'(a);
    bi   = int'($signed(b));
    for (int l = 0; l < 4; l++) begin
      p = int'(d[31-8*l -: 8]);
      s = (ai * p + HALF) / FRAC_DIV + bi;
      if (s < 0) begin
        s = 0;
        nsat++;
      end else if (s > 255) begin
        s = 255;
        nsat++;
      end
      o[31-8*l -: 8] = s[7:0];
    end
  endfunction

  // Compare process: inputs and outputs are stable at the falling edge.
  always @(negedge clk) begin
    logic [W-1:0]  e;
    logic [DW-1:0] o;
    int            ns;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      check("in_ready_en", 64'(in_ready), 64'(!out_valid || out_ready));
      if (prev_stall) begin
        check("stall_valid", 64'(out_valid), 64'(1));
        check("stall_data", 64'(out_data), 64'(prev_data));
        check("stall_sat", 64'(sat_flag), 64'(prev_sat));
      end
`ifdef CONT_BRIGHT_SAT_CNT_EN
      check("sat_count", 64'(sat_count), 64'(cnt_m));
`endif
      if (out_valid && out_ready) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_out", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("out_data", 64'(out_data), 64'(e[DW-1:0]));
          check("sat_flag", 64'(sat_flag), 64'(e[W-1:DW] != 8'd0));
          cnt_m = cnt_m + int'(e[W-1:DW]);
          if (cnt_m > 65535) cnt_m = 65535;
        end
      end
      if (in_valid && in_ready) begin
        model_beat(alpha_m, beta_m, in_data, o, ns);
        exp_q.push_back({8'(ns), o});
      end
      if (cfg_load) begin
        alpha_m = cfg_alpha;
        beta_m  = cfg_beta;
        cnt_m   = 0;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_sat   = sat_flag;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
    in_data  = 32'($urandom);
  endtask

  task automatic load_cfg(input logic [7:0] a, input logic [8:0] b);
    cfg_load  = 1'b1;
    cfg_alpha = a;
    cfg_beta  = b;
    step();
    cfg_load  = 1'b0;
  endtask

  task automatic wait_out(output logic [DW-1:0] d, output logic s, output int lat);
    d   = '0;
    s   = 1'b0;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        d   = out_data;
        s   = sat_flag;
        lat = i;
        return;
      end
    end
    check("out_timeout", 64'(0), 64'(1));
  endtask

  // mode 0: out_ready pattern 1,0,0,1; mode 1: random ready/valid/cfg_load.
  task automatic stream(input int nbeats, input int mode, input int max_cyc);
    int   sent;
    int   cyc;
    logic acc;
    sent     = 0;
    cyc      = 0;
    in_valid = 1'b0;
    while (sent < nbeats && cyc < max_cyc) begin
      if (mode == 0) out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      else           out_ready = ($urandom_range(0, 9) < 6);
      if (!in_valid) begin
        in_valid = (mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 7);
        in_data  = 32'($urandom);
      end
      cfg_load  = (mode == 1) && ($urandom_range(0, 19) == 0);
      cfg_alpha = 8'($urandom);
      cfg_beta  = 9'($urandom);
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc) sent++;
      step();
      if (acc) in_valid = 1'b0;
      cyc++;
    end
    in_valid = 1'b0;
    cfg_load = 1'b0;
    check("stream_sent", 64'(sent), 64'(nbeats));
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    repeat (6) step();
    check("drain_empty", 64'(exp_q.size()), 64'(0));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [DW-1:0] d;
    logic          s;
    int            lat;
    rst       = 1'b1;
    cfg_load  = 1'b0;
    cfg_alpha = '0;
    cfg_beta  = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    #2;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_sat_flag", 64'(sat_flag), 64'(0));
`ifdef CONT_BRIGHT_SAT_CNT_EN
    check("rst_sat_count", 64'(sat_count), 64'(0));
`endif
    repeat (3) step();
    rst = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'(1));

    // Identity with reset coefficients, latency 2.
    step();
    send_one(32'h007F80FF);
    wait_out(d, s, lat);
    check("id_latency", 64'(lat), 64'(2));
    check("id_data", 64'(d), 64'(32'h007F80FF));
    check("id_sat", 64'(s), 64'(0));

    // Gain 2.0, clamping on two lanes.
    step();
    load_cfg(8'h20, 9'h000);
    send_one(32'h107F8090);
    wait_out(d, s, lat);
    check("gain_data", 64'(d), 64'(32'h20FEFFFF));
    check("gain_sat", 64'(s), 64'(1));
`ifdef CONT_BRIGHT_SAT_CNT_EN
    @(negedge clk);
    check("gain_sat_count", 64'(sat_count), 64'(2));
`endif

    // Gain 1.5, beta -20: rounding and clamping at zero.
    step();
    load_cfg(8'h18, 9'h1EC);
    send_one(32'h030A2064);
    wait_out(d, s, lat);
    check("round_data", 64'(d), 64'(32'h00001C82));
    check("round_sat", 64'(s), 64'(1));

    // Beat A accepted with cfg_load uses old (unity) gain; beat B sees 2.0.
    step();
    load_cfg(8'h10, 9'h000);
    cfg_load  = 1'b1;
    cfg_alpha = 8'h20;
    cfg_beta  = 9'h000;
    in_valid  = 1'b1;
    in_data   = 32'h40404040;
    step();
    cfg_load  = 1'b0;
    step();
    in_valid  = 1'b0;
    wait_out(d, s, lat);
    check("coef_a", 64'(d), 64'(32'h40404040));
    wait_out(d, s, lat);
    check("coef_b", 64'(d), 64'(32'h80808080));

    // Backpressure: 8 beats with out_ready 1,0,0,1.
    step();
    load_cfg(8'h1C, 9'h00A);
    stream(8, 0, 200);
    drain();

    // Randomized traffic with coefficient reloads.
    stream(300, 1, 3000);
    drain();

    // Reset with two beats in flight.
    load_cfg(8'h30, 9'h005);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'($urandom);
    step();
    in_data   = 32'($urandom);
    step();
    in_valid  = 1'b0;
    check("pre_rst_valid", 64'(out_valid), 64'(1));
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'(0));
    check("mid_rst_data", 64'(out_data), 64'(0));
    check("mid_rst_sat", 64'(sat_flag), 64'(0));
    exp_q.delete();
    alpha_m = 8'h10;
    beta_m  = 9'h000;
    cnt_m   = 0;
    step();
    step();
    rst     = 1'b0;
    out_cnt = 0;
    step();
    send_one(32'h12345678);
    wait_out(d, s, lat);
    check("post_rst_data", 64'(d), 64'(32'h12345678));
    check("post_rst_sat", 64'(s), 64'(0));
    repeat (5) step();
    check("post_rst_count", 64'(out_cnt), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
